cmd_uart_wrapper: RTL and testbench

// Command front end of MazeRunner; sits between the bluetooth UART pins (RX/TX) and the command processor.

---
 rtl/cmd_uart_wrapper.sv | 187 ++++++++++++++++++
 tb/tb_cmd_uart_wrapper.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/cmd_uart_wrapper.sv
// Command front end: 8N1 UART RX/TX, two-byte command assembly, response serialiser.
// Ports: clk, rst_n, RX, TX, cmd, cmd_rdy, clr_cmd_rdy, resp, send_resp, resp_sent, frm_err.
module cmd_uart_wrapper #(
  parameter int BAUD_DIV   = 2604,
  parameter int TMO_CYCLES = 52080
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        RX,
  output logic        TX,
  output logic [15:0] cmd,
  output logic        cmd_rdy,
  input  logic        clr_cmd_rdy,
  input  logic [7:0]  resp,
  input  logic        send_resp,
  output logic        resp_sent,
  output logic        frm_err
);

  localparam int BW = $clog2(BAUD_DIV) + 1;
  localparam int TW = $clog2(TMO_CYCLES) + 1;
  localparam logic [BW-1:0] BAUD_LAST = BW'(BAUD_DIV - 1);
  localparam logic [BW-1:0] BAUD_HALF = BW'(BAUD_DIV / 2 - 1);
  localparam logic [TW-1:0] TMO_MAX   = TW'(TMO_CYCLES);

  typedef enum logic [1:0] {
    RX_IDLE, RX_START, RX_DATA, RX_STOP
  } rx_state_t;
  typedef enum logic {WAIT_HI, WAIT_LO} asm_state_t;
  typedef enum logic {TX_IDLE, TX_BUSY} tx_state_t;

  // ---------------- RX engine ----------------
  logic          rx_meta, rx_s, rx_prev;
  rx_state_t     rx_state, rx_next;
  logic [BW-1:0] rx_baud;
  logic [3:0]    rx_bits;
  logic [7:0]    rx_shift;
  logic          rx_half, rx_full;
  logic          byte_rdy, frm_set;

  assign rx_half = (rx_baud == BAUD_HALF);
  assign rx_full = (rx_baud == BAUD_LAST);

  always_comb begin
    rx_next  = rx_state;
    byte_rdy = 1'b0;
    frm_set  = 1'b0;
    unique case (rx_state)
      RX_IDLE:  if (rx_prev && !rx_s) rx_next = RX_START;
      RX_START: if (rx_half) rx_next = rx_s ? RX_IDLE : RX_DATA;
      RX_DATA:  if (rx_full && rx_bits == 4'd7) rx_next = RX_STOP;
      RX_STOP: begin
        if (rx_full) begin
          rx_next  = RX_IDLE;
          byte_rdy = rx_s;
          frm_set  = !rx_s;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta  <= 1'b1;
      rx_s     <= 1'b1;
      rx_prev  <= 1'b1;
      rx_state <= RX_IDLE;
      rx_baud  <= '0;
      rx_bits  <= '0;
      rx_shift <= '0;
      frm_err  <= 1'b0;
    end else begin
      rx_meta  <= RX;
      rx_s     <= rx_meta;
      rx_prev  <= rx_s;
      rx_state <= rx_next;
      frm_err  <= frm_set;
      // Restart the bit timer at mid-start so data samples land mid-bit.
      if (rx_state == RX_IDLE || rx_full ||
          (rx_state == RX_START && rx_half))
        rx_baud <= '0;
      else
        rx_baud <= rx_baud + 1'b1;
      if (rx_state != RX_DATA)
        rx_bits <= '0;
      else if (rx_full)
        rx_bits <= rx_bits + 1'b1;
      if (rx_state == RX_DATA && rx_full)
        rx_shift <= {rx_s, rx_shift[7:1]};
    end
  end

  // ---------------- Command assembler ----------------
  asm_state_t    asm_state, asm_next;
  logic [7:0]    hi_hold;
  logic [TW-1:0] tmo_cnt;
  logic          hi_take, lo_take;

  assign hi_take = (asm_state == WAIT_HI) && byte_rdy;
  assign lo_take = (asm_state == WAIT_LO) && byte_rdy;

  always_comb begin
    asm_next = asm_state;
    unique case (asm_state)
      WAIT_HI: if (byte_rdy) asm_next = WAIT_LO;
      WAIT_LO: begin
        if (byte_rdy)              asm_next = WAIT_HI;
        else if (tmo_cnt == TMO_MAX) asm_next = WAIT_HI;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      asm_state <= WAIT_HI;
      hi_hold   <= '0;
      tmo_cnt   <= '0;
      cmd       <= '0;
      cmd_rdy   <= 1'b0;
    end else begin
      asm_state <= asm_next;
      if (hi_take) begin
        hi_hold <= rx_shift;
        tmo_cnt <= '0;
      end else if (asm_state == WAIT_LO && tmo_cnt != TMO_MAX) begin
        tmo_cnt <= tmo_cnt + 1'b1;
      end
      if (lo_take)
        cmd <= {hi_hold, rx_shift};
      // Completion beats a simultaneous clear; a new high byte supersedes a stale cmd.
      if (lo_take)
        cmd_rdy <= 1'b1;
      else if (clr_cmd_rdy || hi_take)
        cmd_rdy <= 1'b0;
    end
  end

  // ---------------- TX engine ----------------
  tx_state_t     tx_state, tx_next;
  logic [BW-1:0] tx_baud;
  logic [3:0]    tx_bits;
  logic [8:0]    tx_shift;
  logic          tx_full, tx_start, tx_end;

  assign tx_full  = (tx_baud == BAUD_LAST);
  assign tx_start = (tx_state == TX_IDLE) && send_resp;
  assign tx_end   = (tx_state == TX_BUSY) && tx_full && tx_bits == 4'd9;

  always_comb begin
    tx_next = tx_state;
    unique case (tx_state)
      TX_IDLE: if (send_resp) tx_next = TX_BUSY;
      TX_BUSY: if (tx_end)    tx_next = TX_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_state  <= TX_IDLE;
      tx_baud   <= '0;
      tx_bits   <= '0;
      tx_shift  <= '1;
      TX        <= 1'b1;
      resp_sent <= 1'b0;
    end else begin
      tx_state <= tx_next;
      if (tx_state == TX_IDLE || tx_full)
        tx_baud <= '0;
      else
        tx_baud <= tx_baud + 1'b1;
      if (tx_start) begin
        tx_shift  <= {1'b1, resp};
        tx_bits   <= '0;
        TX        <= 1'b0;
        resp_sent <= 1'b0;
      end else if (tx_end) begin
        TX        <= 1'b1;
        resp_sent <= 1'b1;
      end else if (tx_state == TX_BUSY && tx_full) begin
        TX       <= tx_shift[0];
        tx_shift <= {1'b1, tx_shift[8:1]};
        tx_bits  <= tx_bits + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_cmd_uart_wrapper.sv
// Directed bench for cmd_uart_wrapper: RX command assembly, framing error,
// timeout, TX response framing and mid-operation reset.
module tb_cmd_uart_wrapper;

  localparam int BD = 16;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        RX;
  logic        TX;
  logic [15:0] cmd;
  logic        cmd_rdy;
  logic        clr_cmd_rdy;
  logic [7:0]  resp;
  logic        send_resp;
  logic        resp_sent;
  logic        frm_err;

  int n_checks = 0;
  int n_errors = 0;
  int comp_cnt = 0;
  int frm_cnt  = 0;
  logic rdy_q = 1'b0;

  cmd_uart_wrapper #(.BAUD_DIV(BD), .TMO_CYCLES(400)) dut (
    .clk(clk), .rst_n(rst_n), .RX(RX), .TX(TX),
    .cmd(cmd), .cmd_rdy(cmd_rdy), .clr_cmd_rdy(clr_cmd_rdy),
    .resp(resp), .send_resp(send_resp),
    .resp_sent(resp_sent), .frm_err(frm_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (cmd_rdy && !rdy_q) comp_cnt = comp_cnt + 1;
    if (frm_err) frm_cnt = frm_cnt + 1;
    rdy_q = cmd_rdy;
  end

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, want %0h", tag, obs, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop);
    RX = 1'b0;
    repeat (BD) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      RX = b[i];
      repeat (BD) @(negedge clk);
    end
    RX = stop;
    repeat (BD) @(negedge clk);
    RX = 1'b1;
    repeat (BD) @(negedge clk);
  endtask

  task automatic pulse_clr();
    clr_cmd_rdy = 1'b1;
    @(negedge clk);
    clr_cmd_rdy = 1'b0;
  endtask

  int base_c, base_f;
  logic [9:0] exp_bits;

  initial begin
    rst_n = 1'b0;
    RX = 1'b1;
    clr_cmd_rdy = 1'b0;
    resp = 8'h00;
    send_resp = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_tx", 32'(TX), 32'h1);
    chk("rst_cmd", 32'(cmd), 32'h0);
    chk("rst_rdy", 32'(cmd_rdy), 32'h0);
    chk("rst_sent", 32'(resp_sent), 32'h0);
    chk("rst_frm", 32'(frm_err), 32'h0);

    // 1: 0x00 0x00
    base_f = frm_cnt;
    send_byte(8'h00, 1'b1);
    send_byte(8'h00, 1'b1);
    chk("t1_rdy", 32'(cmd_rdy), 32'h1);
    chk("t1_cmd", 32'(cmd), 32'h0);
    chk("t1_frm", 32'(frm_cnt - base_f), 32'h0);
    pulse_clr();

    // 2: 0x23 0xFF then clear
    send_byte(8'h23, 1'b1);
    send_byte(8'hFF, 1'b1);
    chk("t2_rdy", 32'(cmd_rdy), 32'h1);
    chk("t2_cmd", 32'(cmd), 32'h23FF);
    pulse_clr();
    chk("t2_clr", 32'(cmd_rdy), 32'h0);
    chk("t2_hold", 32'(cmd), 32'h23FF);

    // 3: stale high byte times out
    base_c = comp_cnt;
    send_byte(8'h23, 1'b1);
    repeat (500) @(negedge clk);
    chk("t3_part", 32'(cmd), 32'h23FF);
    send_byte(8'h40, 1'b1);
    send_byte(8'h01, 1'b1);
    chk("t3_cnt", 32'(comp_cnt - base_c), 32'h1);
    chk("t3_cmd", 32'(cmd), 32'h4001);
    pulse_clr();

    // 4: framing error then 0x12 0x34
    base_f = frm_cnt;
    base_c = comp_cnt;
    send_byte(8'h5A, 1'b0);
    chk("t4_frm", 32'(frm_cnt - base_f), 32'h1);
    chk("t4_nordy", 32'(cmd_rdy), 32'h0);
    send_byte(8'h12, 1'b1);
    send_byte(8'h34, 1'b1);
    chk("t4_cmd", 32'(cmd), 32'h1234);
    chk("t4_cnt", 32'(comp_cnt - base_c), 32'h1);
    chk("t4_frm1", 32'(frm_cnt - base_f), 32'h1);

    // 5: response 0xA5, second send_resp at cycle 50 ignored
    exp_bits = 10'b1101001010;
    resp = 8'hA5;
    send_resp = 1'b1;
    for (int c = 0; c < 170; c++) begin
      @(negedge clk);
      send_resp = (c == 50);
      if (c == 50) resp = 8'h3C;
      if (c == 0) chk("t5_sent0", 32'(resp_sent), 32'h0);
      if (c < 160 && c % BD == 8)
        chk($sformatf("t5_bit%0d", c / BD), 32'(TX), 32'(exp_bits[c / BD]));
      if (c == 159) chk("t5_sent159", 32'(resp_sent), 32'h0);
      if (c == 160) chk("t5_sent160", 32'(resp_sent), 32'h1);
      if (c == 165) chk("t5_idle", 32'(TX), 32'h1);
    end
    send_resp = 1'b0;

    // 6: reset during RX byte and TX frame (cmd_rdy still set from test 4)
    chk("t6_pre", 32'(cmd_rdy), 32'h1);
    fork
      send_byte(8'h77, 1'b1);
      begin
        resp = 8'h00;
        send_resp = 1'b1;
        @(negedge clk);
        send_resp = 1'b0;
        repeat (60) @(negedge clk);
        chk("t6_txlow", 32'(TX), 32'h0);
        rst_n = 1'b0;
        @(negedge clk);
        chk("t6_tx", 32'(TX), 32'h1);
        chk("t6_rdy", 32'(cmd_rdy), 32'h0);
        chk("t6_cmd", 32'(cmd), 32'h0);
      end
    join
    rst_n = 1'b1;
    repeat (BD) @(negedge clk);
    chk("t6_txidle", 32'(TX), 32'h1);
    chk("t6_sent", 32'(resp_sent), 32'h0);
    send_byte(8'h23, 1'b1);
    send_byte(8'hFF, 1'b1);
    chk("t6_rdy2", 32'(cmd_rdy), 32'h1);
    chk("t6_cmd2", 32'(cmd), 32'h23FF);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
